// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EXE/MEM/WB control sequencer: owns pc, latches ir, counts retired instructions.
// Optional single-step PAUSE state and `step` input when SEQ_STEP_EN is defined.
module multicycle_sequencer #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned RET_W = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             run,
`ifdef SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [2:0]       opcode,
    input  logic [2:0]       aux,
    input  logic             zero,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       ir_op,
    output logic [2:0]       ir_aux,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             regwrite,
    output logic             busy,
    output logic             halted,
    output logic [RET_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALTED    = 3'd6
`ifdef SEQ_STEP_EN
        , PAUSE   = 3'd7
`endif
    } state_t;

    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_BZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t          fsm;
    state_t          nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] bz_off;
    logic [2:0]      ir_op_nxt;
    logic [2:0]      ir_aux_nxt;
    logic            retire;
    logic            busy_nxt;

    assign bz_off = {{(PC_W-3){ir_aux[2]}}, ir_aux};
    assign state  = fsm;

    always_comb begin
        nxt        = fsm;
        pc_nxt     = pc;
        ir_op_nxt  = ir_op;
        ir_aux_nxt = ir_aux;
        retire     = 1'b0;
        case (fsm)
            IDLE: begin
                if (run) nxt = FETCH;
            end
            FETCH: begin
                ir_op_nxt  = opcode;
                ir_aux_nxt = aux;
                pc_nxt     = pc + PC_W'(1);
                nxt        = DECODE;
            end
            DECODE: begin
                nxt = (ir_op == OP_HALT) ? HALTED : EXECUTE;
            end
            EXECUTE: begin
                if (ir_op == OP_BZ) begin
                    retire = 1'b1;
                    if (zero) pc_nxt = pc + bz_off;
                end else if (ir_op == OP_LD || ir_op == OP_ST) begin
                    nxt = MEMORY;
                end else begin
                    nxt = WRITEBACK;
                end
            end
            MEMORY: begin
                if (mem_ack) begin
                    if (ir_op == OP_LD) nxt = WRITEBACK;
                    else                retire = 1'b1;
                end
            end
            WRITEBACK: begin
                retire = 1'b1;
            end
            HALTED: begin
                nxt = HALTED;
            end
`ifdef SEQ_STEP_EN
            PAUSE: begin
                if (step) nxt = FETCH;
            end
`endif
            default: begin
                nxt = IDLE;
            end
        endcase
`ifdef SEQ_STEP_EN
        if (retire) nxt = PAUSE;
        busy_nxt = (nxt != IDLE) && (nxt != HALTED) && (nxt != PAUSE);
`else
        if (retire) nxt = FETCH;
        busy_nxt = (nxt != IDLE) && (nxt != HALTED);
`endif
    end

    // Enables are registered from the next state, so each one is a pure decode of the
    // state register and latched ir after the edge and never follows an input combinationally.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            fsm      <= IDLE;
            pc       <= '0;
            ir_op    <= '0;
            ir_aux   <= '0;
            retired  <= '0;
            alu_en   <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            regwrite <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            fsm      <= nxt;
            pc       <= pc_nxt;
            ir_op    <= ir_op_nxt;
            ir_aux   <= ir_aux_nxt;
            if (retire) retired <= retired + RET_W'(1);
            alu_en   <= (nxt == EXECUTE);
            mem_req  <= (nxt == MEMORY);
            mem_we   <= (nxt == MEMORY) && (ir_op_nxt == OP_ST);
            regwrite <= (nxt == WRITEBACK);
            busy     <= busy_nxt;
            halted   <= (nxt == HALTED);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized program run against a per-instruction reference model; a negedge monitor pops
// expected retire/halt records from a queue and checks observed enables, cycles, pc and counters.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned RET_W = 16;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_BZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam int unsigned N_INSTR = 400;

    logic             sysclk = 1'b0;
    logic             reset;
    logic             run;
    logic             zero;
    logic             mem_ack;
    logic [2:0]       opcode;
    logic [2:0]       aux;
`ifdef SEQ_STEP_EN
    logic             step;
`endif
    logic [PC_W-1:0]  pc;
    logic [2:0]       ir_op;
    logic [2:0]       ir_aux;
    logic             alu_en;
    logic             mem_req;
    logic             mem_we;
    logic             regwrite;
    logic             busy;
    logic             halted;
    logic [RET_W-1:0] retired;
    logic [2:0]       state;

    logic [2:0] imem_op  [256];
    logic [2:0] imem_aux [256];

    assign opcode = imem_op[pc];
    assign aux    = imem_aux[pc];

    always #5 sysclk = ~sysclk;

    multicycle_sequencer #(.PC_W(PC_W), .RET_W(RET_W)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .run      (run),
`ifdef SEQ_STEP_EN
        .step     (step),
`endif
        .opcode   (opcode),
        .aux      (aux),
        .zero     (zero),
        .mem_ack  (mem_ack),
        .pc       (pc),
        .ir_op    (ir_op),
        .ir_aux   (ir_aux),
        .alu_en   (alu_en),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .regwrite (regwrite),
        .busy     (busy),
        .halted   (halted),
        .retired  (retired),
        .state    (state)
    );

    typedef struct {
        int unsigned cycles;
        int unsigned alu;
        int unsigned req;
        int unsigned we;
        int unsigned rw;
        int unsigned pc_after;
        int unsigned ret;
        int unsigned op;
        int unsigned aux;
    } exp_t;

    exp_t sbq[$];
    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: an instruction is complete when retired moves or halted rises.
    bit               mon_en = 1'b0;
    logic [RET_W-1:0] m_last_ret;
    logic             m_last_halt;
    int unsigned      m_cyc, m_alu, m_req, m_we, m_rw;

    always @(negedge sysclk) begin
        if (!mon_en) begin
            m_last_ret  = retired;
            m_last_halt = halted;
            m_cyc = 0; m_alu = 0; m_req = 0; m_we = 0; m_rw = 0;
        end else begin
            if (retired !== m_last_ret || (halted === 1'b1 && m_last_halt !== 1'b1)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL sb_underflow: got completion at pc=%0d with 0 queued, expected 1", pc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("cycles",   m_cyc,   e.cycles);
                    chk("alu_en",   m_alu,   e.alu);
                    chk("mem_req",  m_req,   e.req);
                    chk("mem_we",   m_we,    e.we);
                    chk("regwrite", m_rw,    e.rw);
                    chk("pc",       32'(pc), e.pc_after);
                    chk("retired",  32'(retired), e.ret);
                    chk("ir_op",    32'(ir_op),   e.op);
                    chk("ir_aux",   32'(ir_aux),  e.aux);
                end
                m_cyc = 0; m_alu = 0; m_req = 0; m_we = 0; m_rw = 0;
            end
            m_last_ret  = retired;
            m_last_halt = halted;
            if (busy)     m_cyc++;
            if (alu_en)   m_alu++;
            if (mem_req)  m_req++;
            if (mem_we)   m_we++;
            if (regwrite) m_rw++;
        end
    end

    // Reference model: architectural pc/retired bookkeeping per instruction.
    int unsigned m_pc  = 0;
    int unsigned m_ret = 0;

    task automatic issue(input int unsigned idx);
        exp_t        e;
        logic [2:0]  op;
        logic [2:0]  ax;
        int unsigned n;
        int          s;
        bit          z;
        bit          is_mem;
        op = imem_op[m_pc];
        ax = imem_aux[m_pc];
        z  = (idx == 5) ? 1'b1 : ((idx < 8) ? 1'b0 : 1'($urandom_range(0, 1)));
        n  = (idx < 8) ? 3 : $urandom_range(1, 4);
        s  = ax[2] ? int'(ax) - 8 : int'(ax);
        is_mem = (op == OP_LD) || (op == OP_ST);
        e = '{default: 0};
        e.op = op;
        e.aux = ax;
        e.pc_after = (m_pc + 1) % 256;
        if (op == OP_HALT) begin
            e.cycles = 2;
        end else begin
            e.alu = 1;
            if (op == OP_LD) begin
                e.cycles = 4 + n; e.req = n; e.rw = 1;
            end else if (op == OP_ST) begin
                e.cycles = 3 + n; e.req = n; e.we = n;
            end else if (op == OP_BZ) begin
                e.cycles = 3;
                if (z) e.pc_after = (int'(m_pc) + 1 + s + 256) % 256;
            end else begin
                e.cycles = 4; e.rw = 1;
            end
            m_ret = (m_ret + 1) % (1 << RET_W);
        end
        e.ret = m_ret;
        sbq.push_back(e);
        for (int c = 0; c < int'(e.cycles); c++) begin
            run  = 1'($urandom_range(0, 1));
            zero = (c == 2) ? z : 1'($urandom_range(0, 1));
            if (is_mem && c >= 3 && c < 3 + int'(n)) mem_ack = (c == 3 + int'(n) - 1);
            else                                      mem_ack = 1'($urandom_range(0, 1));
            @(posedge sysclk); #1;
        end
        m_pc = e.pc_after;
`ifdef SEQ_STEP_EN
        if (op != OP_HALT) begin
            @(posedge sysclk); #1;
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ack = 1'b0;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        for (int i = 0; i < 256; i++) begin
            imem_op[i]  = 3'($urandom_range(0, 6));
            imem_aux[i] = 3'($urandom_range(0, 7));
        end
        imem_op[0] = 3'b001;
        imem_op[1] = OP_LD;
        imem_op[2] = 3'b010;
        imem_op[3] = OP_ST;
        imem_op[4] = 3'b000;
        imem_op[5] = OP_BZ; imem_aux[5] = 3'b110;

        repeat (2) @(posedge sysclk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("idle_state",   32'(state),   0);
            chk("idle_pc",      32'(pc),      0);
            chk("idle_retired", 32'(retired), 0);
            chk("idle_enables", {26'd0, alu_en, mem_req, mem_we, regwrite, busy, halted}, 0);
            @(posedge sysclk); #1;
        end

        run = 1'b1;
        mon_en = 1'b1;
        @(posedge sysclk); #1;
        for (int unsigned i = 0; i < N_INSTR; i++) issue(i);
        imem_op[m_pc] = OP_HALT;
        issue(N_INSTR);

        for (int i = 0; i < 6; i++) begin
            run = ~run;
            chk("halt_halted", 32'(halted), 1);
            chk("halt_busy",   32'(busy),   0);
            chk("halt_state",  32'(state),  6);
            chk("halt_pc",     32'(pc),     m_pc);
            @(posedge sysclk); #1;
        end
        chk("sb_drain", sbq.size(), 0);

        // Store abandoned by an asynchronous reset while waiting for ack.
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_state",   32'(state),   0);
        chk("rst_pc",      32'(pc),      0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_halted",  32'(halted),  0);
        @(posedge sysclk); #1;
        reset = 1'b0; imem_op[0] = OP_ST; mem_ack = 1'b0; run = 1'b1;
        @(posedge sysclk); #1;
        run = 1'b0;
        repeat (3) begin
            @(posedge sysclk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            chk("st_wait_req",   32'(mem_req), 1);
            chk("st_wait_we",    32'(mem_we),  1);
            chk("st_wait_state", 32'(state),   4);
            @(posedge sysclk); #1;
        end
        #2 reset = 1'b1;
        #1;
        chk("st_rst_req",     32'(mem_req), 0);
        chk("st_rst_we",      32'(mem_we),  0);
        chk("st_rst_state",   32'(state),   0);
        chk("st_rst_retired", 32'(retired), 0);
        @(posedge sysclk); #1;
        reset = 1'b0;

`ifdef SEQ_STEP_EN
        imem_op[0] = 3'b011; step = 1'b0; run = 1'b1;
        @(posedge sysclk); #1;
        run = 1'b0;
        repeat (4) begin
            @(posedge sysclk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk("pause_state", 32'(state), 7);
            chk("pause_busy",  32'(busy),  0);
            @(posedge sysclk); #1;
        end
        step = 1'b1;
        @(posedge sysclk); #1;
        step = 1'b0;
        chk("step_fetch", 32'(state), 1);
        chk("step_retired", 32'(retired), 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the 8-bit IF/ID/EXE/MEM/WB datapath. Owns the program counter, holds the fetched opcode/immediate, and steps each instruction through fetch, decode, execute, memory and writeback, asserting the matching datapath enables. It waits on a req/ack handshake to the data memory and stops on HALT.

## Interface
Parameters:
- PC_W, 8, program counter width; PC arithmetic is modulo 2^PC_W.
- RET_W, 16, width of the retired-instruction counter.

Ports:
- sysclk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; leaves IDLE when sampled high.
- opcode  input  3  instruction opcode from instruction memory, valid for the current pc.
- aux  input  3  instruction immediate/function field from instruction memory.
- zero  input  1  high when register operand 0 equals 0; sampled in EXECUTE.
- mem_ack  input  1  data memory completion, sampled in MEMORY.
- pc  output  PC_W  program counter driven to instruction memory.
- ir_op  output  3  latched opcode.
- ir_aux  output  3  latched aux.
- alu_en  output  1  high in EXECUTE.
- mem_req  output  1  high in MEMORY.
- mem_we  output  1  high in MEMORY when ir_op is ST.
- regwrite  output  1  high in WRITEBACK.
- busy  output  1  high in every state except IDLE and HALTED.
- halted  output  1  high in HALTED.
- retired  output  RET_W  count of completed non-HALT instructions.
- state  output  3  encoded FSM state for debug.

## Operation
- Opcode map: 000-011 ALU (reg or imm, per decode), 100 LD, 101 ST, 110 BZ, 111 HALT.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, PAUSE=7 (PAUSE exists only with SEQ_STEP_EN).
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: latch opcode/aux into ir_op/ir_aux; pc <= pc+1 (255 wraps to 0); -> DECODE.
- DECODE: ir_op=HALT -> HALTED; otherwise -> EXECUTE.
- EXECUTE:
  - ALU op -> WRITEBACK.
  - LD or ST -> MEMORY.
  - BZ: if zero, pc <= pc + sign_extend(ir_aux) (range -4..+3, relative to the incremented pc, modulo 256). Then the instruction retires.
- MEMORY: hold mem_req until mem_ack is sampled high. With ack, LD -> WRITEBACK; ST retires. mem_ack outside MEMORY is ignored.
- WRITEBACK: regwrite for exactly one cycle, then retire.
- Retire: retired <= retired+1 (wraps at 2^RET_W-1 -> 0). Next state is FETCH, or PAUSE with SEQ_STEP_EN.
- HALTED is sticky. Only reset leaves it; run is ignored there.
- All control outputs decode from the state register and latched ir only, never combinationally from inputs.

## Timing
- Reset: state=IDLE, pc=0, ir_op=0, ir_aux=0, retired=0, and all control outputs 0, applied immediately (asynchronous).
- Cycles per instruction (no pause):
  - ALU: 4 (F,D,E,W).
  - LD: 4 + n, where n ≥ 1 MEMORY cycles up to and including the ack cycle.
  - ST: 3 + n.
  - BZ: 3.
  - HALT: 2, then HALTED.
- mem_ack high in the first MEMORY cycle gives n=1. mem_req falls in the cycle after ack is sampled.
- Reset asserted mid-MEMORY drops mem_req and mem_we in the same cycle. An in-flight store is abandoned and does not retire.
- pc changes only at the FETCH->DECODE edge and on a taken BZ at EXECUTE exit.

## Configuration
- SEQ_STEP_EN defined:
  - Adds input port `step` (1 bit).
  - After each retire the FSM enters PAUSE with busy=0.
  - A sampled step=1 -> FETCH. step held high advances one instruction per retire.
- SEQ_STEP_EN undefined: no step port, no PAUSE state; retire goes directly to FETCH.

## Test plan
- Reset, then run=0 for 5 cycles: pc=0, state=0, retired=0, and all enables 0 throughout.
- ALU op 001 at pc=0, run=1: states 1,2,3,5; regwrite high only in cycle 4; pc=1 and retired=1 afterwards.
- LD with mem_ack delayed 3 cycles: mem_req high for 3 cycles, mem_we=0, then one regwrite cycle; 7 cycles total.
- BZ at pc=5, aux=3'b110, zero=1: pc=4 after EXECUTE. Repeat with zero=0: pc=6.
- Instruction at pc=255: pc wraps to 0. HALT fetched: halted=1 and busy=0; run toggling has no effect until reset.
- ST in MEMORY with mem_ack=0, assert reset: mem_req and mem_we drop immediately, retired unchanged, state=IDLE. With SEQ_STEP_EN, PAUSE holds until a one-cycle step pulse.
